// File: rtl/sched_pkg.sv
// Shared encodings and default sizing for the round-robin process scheduler.
// The defaults are also referenced by the CPU top level.
package sched_pkg;

    localparam int unsigned N_PROC_DEF  = 4;
    localparam int unsigned QUANTUM_DEF = 16;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_READY   = 2'd1,
        SLOT_RUNNING = 2'd2,
        SLOT_BLOCKED = 2'd3
    } slot_state_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_SELECT   = 2'd2,
        ST_DISPATCH = 2'd3
    } fsm_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set bit of ready_mask scanning
// start, start+1, ... modulo N_PROC.
module rr_pick #(
    parameter int unsigned N_PROC = 4,
    parameter int unsigned PID_W  = 2
) (
    input  logic [N_PROC-1:0] ready_mask,
    input  logic [PID_W-1:0]  start,
    output logic              found,
    output logic [PID_W-1:0]  pid
);

    always_comb begin
        found = 1'b0;
        pid   = '0;
        for (int unsigned k = 0; k < N_PROC; k++) begin
            int unsigned idx;
            idx = (32'(start) + k) % N_PROC;
            if (!found && ready_mask[PID_W'(idx)]) begin
                found = 1'b1;
                pid   = PID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin process scheduler: process table, quantum counter and the
// IDLE/RUN/SELECT/DISPATCH control that hands the next PID/PC to the CPU.
module process_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned N_PROC  = N_PROC_DEF,
    parameter int unsigned PID_W   = $clog2(N_PROC),
    parameter int unsigned QUANTUM = QUANTUM_DEF,
    parameter int unsigned PC_W    = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             create_valid,
    input  logic [PID_W-1:0] create_pid,
    input  logic [PC_W-1:0]  create_pc,
    input  logic             instr_retire,
    input  logic             io_req,
    input  logic             proc_end,
    input  logic [PC_W-1:0]  save_pc,
    input  logic             io_done_valid,
    input  logic [PID_W-1:0] io_done_pid,
    input  logic             switch_ack,
    output logic             switch_valid,
    output logic [PID_W-1:0] next_pid,
    output logic [PC_W-1:0]  next_pc,
    output logic [PID_W-1:0] cur_pid,
    output logic             idle,
    output logic             create_err
);

    localparam int unsigned CNT_W = $clog2(QUANTUM);

    slot_state_e      slot_q [N_PROC];
    slot_state_e      slot_d [N_PROC];
    logic [PC_W-1:0]  pc_q   [N_PROC];
    logic [PC_W-1:0]  pc_d   [N_PROC];
    fsm_state_e       fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PID_W-1:0] cur_pid_q, cur_pid_d;
    logic [PID_W-1:0] next_pid_q, next_pid_d;
    logic [PC_W-1:0]  next_pc_q, next_pc_d;
    logic             switch_valid_q, switch_valid_d;
    logic             idle_q, idle_d;
    logic             create_err_q, create_err_d;

    logic [N_PROC-1:0] ready_mask;
    logic [PID_W-1:0]  start_ptr;
    logic              pick_found;
    logic [PID_W-1:0]  pick_pid;

    always_comb begin
        for (int unsigned i = 0; i < N_PROC; i++) begin
            ready_mask[i] = (slot_q[i] == SLOT_READY);
        end
    end

    // The search ends on cur_pid so a lone expired process is re-dispatched.
    assign start_ptr = PID_W'((32'(cur_pid_q) + 32'd1) % N_PROC);

    rr_pick #(
        .N_PROC (N_PROC),
        .PID_W  (PID_W)
    ) u_rr_pick (
        .ready_mask (ready_mask),
        .start      (start_ptr),
        .found      (pick_found),
        .pid        (pick_pid)
    );

    always_comb begin
        slot_d         = slot_q;
        pc_d           = pc_q;
        fsm_d          = fsm_q;
        cnt_d          = cnt_q;
        cur_pid_d      = cur_pid_q;
        next_pid_d     = next_pid_q;
        next_pc_d      = next_pc_q;
        switch_valid_d = switch_valid_q;
        create_err_d   = 1'b0;

        case (fsm_q)
            ST_IDLE: begin
                if (|ready_mask) fsm_d = ST_SELECT;
            end
            ST_RUN: begin
                if (proc_end) begin
                    slot_d[cur_pid_q] = SLOT_EMPTY;
                    cnt_d             = '0;
                    fsm_d             = ST_SELECT;
                end else if (io_req) begin
                    slot_d[cur_pid_q] = SLOT_BLOCKED;
                    pc_d[cur_pid_q]   = save_pc;
                    cnt_d             = '0;
                    fsm_d             = ST_SELECT;
                end else if (instr_retire) begin
                    if (cnt_q == CNT_W'(QUANTUM - 1)) begin
                        slot_d[cur_pid_q] = SLOT_READY;
                        pc_d[cur_pid_q]   = save_pc;
                        cnt_d             = '0;
                        fsm_d             = ST_SELECT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_SELECT: begin
                if (pick_found) begin
                    next_pid_d     = pick_pid;
                    next_pc_d      = pc_q[pick_pid];
                    switch_valid_d = 1'b1;
                    fsm_d          = ST_DISPATCH;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (switch_ack) begin
                    slot_d[next_pid_q] = SLOT_RUNNING;
                    cur_pid_d          = next_pid_q;
                    switch_valid_d     = 1'b0;
                    cnt_d              = '0;
                    fsm_d              = ST_RUN;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase

        // Create and io_done check the registered table, so they never collide
        // with the running slot's event or the slot being dispatched.
        if (create_valid) begin
            if (slot_q[create_pid] == SLOT_EMPTY) begin
                slot_d[create_pid] = SLOT_READY;
                pc_d[create_pid]   = create_pc;
            end else begin
                create_err_d = 1'b1;
            end
        end
        if (io_done_valid && slot_q[io_done_pid] == SLOT_BLOCKED) begin
            slot_d[io_done_pid] = SLOT_READY;
        end

        idle_d = (fsm_d == ST_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < N_PROC; i++) begin
                slot_q[i] <= SLOT_EMPTY;
                pc_q[i]   <= '0;
            end
            fsm_q          <= ST_IDLE;
            cnt_q          <= '0;
            cur_pid_q      <= '0;
            next_pid_q     <= '0;
            next_pc_q      <= '0;
            switch_valid_q <= 1'b0;
            idle_q         <= 1'b1;
            create_err_q   <= 1'b0;
        end else begin
            slot_q         <= slot_d;
            pc_q           <= pc_d;
            fsm_q          <= fsm_d;
            cnt_q          <= cnt_d;
            cur_pid_q      <= cur_pid_d;
            next_pid_q     <= next_pid_d;
            next_pc_q      <= next_pc_d;
            switch_valid_q <= switch_valid_d;
            idle_q         <= idle_d;
            create_err_q   <= create_err_d;
        end
    end

    assign switch_valid = switch_valid_q;
    assign next_pid     = next_pid_q;
    assign next_pc      = next_pc_q;
    assign cur_pid      = cur_pid_q;
    assign idle         = idle_q;
    assign create_err   = create_err_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: expected dispatches are queued when
// the triggering stimulus is driven and compared when switch_valid appears.
module tb_process_scheduler;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        create_valid = 1'b0;
    logic [1:0]  create_pid = '0;
    logic [31:0] create_pc = '0;
    logic        instr_retire = 1'b0;
    logic        io_req = 1'b0;
    logic        proc_end = 1'b0;
    logic [31:0] save_pc = '0;
    logic        io_done_valid = 1'b0;
    logic [1:0]  io_done_pid = '0;
    logic        switch_ack = 1'b0;
    logic        switch_valid;
    logic [1:0]  next_pid;
    logic [31:0] next_pc;
    logic [1:0]  cur_pid;
    logic        idle;
    logic        create_err;

    typedef struct packed {
        logic [1:0]  pid;
        logic [31:0] pc;
    } disp_t;

    disp_t sb[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    process_scheduler #(
        .N_PROC  (4),
        .PID_W   (2),
        .QUANTUM (16),
        .PC_W    (32)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .create_valid  (create_valid),
        .create_pid    (create_pid),
        .create_pc     (create_pc),
        .instr_retire  (instr_retire),
        .io_req        (io_req),
        .proc_end      (proc_end),
        .save_pc       (save_pc),
        .io_done_valid (io_done_valid),
        .io_done_pid   (io_done_pid),
        .switch_ack    (switch_ack),
        .switch_valid  (switch_valid),
        .next_pid      (next_pid),
        .next_pc       (next_pc),
        .cur_pid       (cur_pid),
        .idle          (idle),
        .create_err    (create_err)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_create(input logic [1:0] pid, input logic [31:0] pc);
        create_valid = 1'b1;
        create_pid   = pid;
        create_pc    = pc;
        tick();
        create_valid = 1'b0;
    endtask

    task automatic do_retire(input int unsigned n, input logic [31:0] last_pc);
        for (int unsigned i = 0; i < n; i++) begin
            instr_retire = 1'b1;
            save_pc      = (i == n - 1) ? last_pc : 32'h0;
            tick();
        end
        instr_retire = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] pid, input logic [31:0] pc);
        disp_t e;
        e.pid = pid;
        e.pc  = pc;
        sb.push_back(e);
    endtask

    // Bounded wait for a dispatch request, then compare it with the scoreboard head.
    task automatic expect_dispatch(input string tag);
        int unsigned n;
        disp_t e;
        n = 0;
        while (switch_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'h0, switch_valid}, 32'h1);
        check({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'h1 : 32'h0, 32'h1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_pid"}, {30'h0, next_pid}, {30'h0, e.pid});
            check({tag, "_pc"}, next_pc, e.pc);
        end
    endtask

    task automatic do_ack(input string tag, input logic [1:0] pid);
        switch_ack = 1'b1;
        tick();
        switch_ack = 1'b0;
        check({tag, "_ack_valid_low"}, {31'h0, switch_valid}, 32'h0);
        check({tag, "_ack_cur_pid"}, {30'h0, cur_pid}, {30'h0, pid});
        check({tag, "_ack_idle"}, {31'h0, idle}, 32'h0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_switch_valid", {31'h0, switch_valid}, 32'h0);
        check("rst_next_pid", {30'h0, next_pid}, 32'h0);
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_cur_pid", {30'h0, cur_pid}, 32'h0);
        check("rst_idle", {31'h0, idle}, 32'h1);
        check("rst_create_err", {31'h0, create_err}, 32'h0);
        reset = 1'b1;
        tick();

        // First dispatch, ack withheld for two cycles
        push_exp(2'd0, 32'h40);
        do_create(2'd0, 32'h40);
        check("create0_err", {31'h0, create_err}, 32'h0);
        expect_dispatch("disp0");
        tick();
        tick();
        check("disp0_hold_valid", {31'h0, switch_valid}, 32'h1);
        check("disp0_hold_pc", next_pc, 32'h40);
        do_ack("disp0", 2'd0);

        // Quantum expiry: 15 retires are not enough, the 16th expires
        do_create(2'd1, 32'h60);
        do_retire(15, 32'h0);
        tick();
        check("no_early_expiry", {31'h0, switch_valid}, 32'h0);
        push_exp(2'd1, 32'h60);
        do_retire(1, 32'h50);
        expect_dispatch("expiry_p1");
        do_ack("expiry_p1", 2'd1);

        // I/O block with exact latency, then io_done and resume at saved PC
        io_req  = 1'b1;
        save_pc = 32'h77;
        push_exp(2'd0, 32'h50);
        tick();
        io_req = 1'b0;
        check("io_lat_e0", {31'h0, switch_valid}, 32'h0);
        tick();
        check("io_lat_e1", {31'h0, switch_valid}, 32'h1);
        expect_dispatch("io_p0");
        do_ack("io_p0", 2'd0);
        io_done_valid = 1'b1;
        io_done_pid   = 2'd1;
        tick();
        io_done_valid = 1'b0;
        push_exp(2'd1, 32'h77);
        do_retire(16, 32'h88);
        expect_dispatch("iodone_p1");
        do_ack("iodone_p1", 2'd1);

        // Drain to a single process, then proc_end leaves the scheduler idle
        proc_end = 1'b1;
        push_exp(2'd0, 32'h88);
        tick();
        proc_end = 1'b0;
        expect_dispatch("end_p1");
        do_ack("end_p1", 2'd0);
        proc_end = 1'b1;
        tick();
        proc_end = 1'b0;
        tick();
        tick();
        check("all_end_idle", {31'h0, idle}, 32'h1);
        push_exp(2'd2, 32'h20);
        do_create(2'd2, 32'h20);
        expect_dispatch("lone_p2");
        do_ack("lone_p2", 2'd2);
        proc_end = 1'b1;
        tick();
        proc_end = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("p2_end_idle", {31'h0, idle}, 32'h1);
        check("p2_end_no_valid", {31'h0, switch_valid}, 32'h0);
        push_exp(2'd3, 32'h10);
        do_create(2'd3, 32'h10);
        expect_dispatch("create_p3");
        do_ack("create_p3", 2'd3);

        // Lone process expiry re-dispatches itself at its saved PC
        push_exp(2'd3, 32'h30);
        do_retire(16, 32'h30);
        expect_dispatch("self_p3");
        do_ack("self_p3", 2'd3);

        // Create on the RUNNING slot is rejected
        do_create(2'd3, 32'hABC);
        check("create_running_err", {31'h0, create_err}, 32'h1);

        // proc_end beats io_req: slot ends EMPTY, so io_done cannot revive it
        do_create(2'd0, 32'h100);
        proc_end = 1'b1;
        io_req   = 1'b1;
        save_pc  = 32'hDEAD;
        push_exp(2'd0, 32'h100);
        tick();
        proc_end = 1'b0;
        io_req   = 1'b0;
        expect_dispatch("prio_p0");
        do_ack("prio_p0", 2'd0);
        io_done_valid = 1'b1;
        io_done_pid   = 2'd3;
        tick();
        io_done_valid = 1'b0;
        do_create(2'd3, 32'h200);
        check("prio_slot_empty", {31'h0, create_err}, 32'h0);
        do_create(2'd3, 32'h999);
        check("create_ready_err", {31'h0, create_err}, 32'h1);
        tick();
        check("create_err_pulse", {31'h0, create_err}, 32'h0);
        push_exp(2'd3, 32'h200);
        do_retire(16, 32'h104);
        expect_dispatch("pc_kept_p3");
        do_ack("pc_kept_p3", 2'd3);

        // Reset while a dispatch is pending and unacknowledged
        io_req  = 1'b1;
        save_pc = 32'h300;
        push_exp(2'd0, 32'h104);
        tick();
        io_req = 1'b0;
        expect_dispatch("pre_reset_p0");
        reset = 1'b0;
        #2;
        check("async_rst_valid", {31'h0, switch_valid}, 32'h0);
        check("async_rst_cur_pid", {30'h0, cur_pid}, 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_idle", {31'h0, idle}, 32'h1);
        check("post_rst_no_valid", {31'h0, switch_valid}, 32'h0);
        for (int p = 0; p < 4; p++) begin
            do_create(2'(p), 32'h1000 + 32'(p));
            check($sformatf("post_rst_empty_%0d", p), {31'h0, create_err}, 32'h0);
        end
        push_exp(2'd1, 32'h1001);
        expect_dispatch("post_rst_p1");
        do_ack("post_rst_p1", 2'd1);

        // Events are ignored outside RUN: a retire burst during dispatch does nothing
        proc_end = 1'b1;
        push_exp(2'd2, 32'h1002);
        tick();
        proc_end = 1'b0;
        tick();
        instr_retire = 1'b1;
        io_req       = 1'b1;
        tick();
        instr_retire = 1'b0;
        io_req       = 1'b0;
        expect_dispatch("ignore_p2");
        do_ack("ignore_p2", 2'd2);

        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
